// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// reg_file_mp_if : read / write / issue bundle of the multi-port regfile
// rev 1.0
// ----------------------------------------------------------------------
interface reg_file_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr0_en;
   logic [ADDR_W-1:0]        wr0_addr;
   logic [DATA_W-1:0]        wr0_data;
   logic                     wr1_en;
   logic [ADDR_W-1:0]        wr1_addr;
   logic [DATA_W-1:0]        wr1_data;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     waw_err;

   modport master (
      output rd_addr, wr0_en, wr0_addr, wr0_data,
      output wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
      input  rd_data, rd_busy, waw_err
   );

   modport slave (
      input  rd_addr, wr0_en, wr0_addr, wr0_data,
      input  wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
      output rd_data, rd_busy, waw_err
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ----------------------------------------------------------------------
// reg_file_mp : multi-port register file with dual write and busy scoreboard
// rev 1.0
// ----------------------------------------------------------------------
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   reg_file_mp_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic              waw_err_q, waw_err_d;
   logic              w_wr0_ok, w_wr1_ok, w_iss_ok, w_iss_clr;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   assign w_wr0_ok  = bus.wr0_en && !is_zero(bus.wr0_addr);
   assign w_wr1_ok  = bus.wr1_en && !is_zero(bus.wr1_addr);
   assign w_iss_ok  = bus.iss_en && !is_zero(bus.iss_addr);
   assign w_iss_clr = (w_wr0_ok && (bus.wr0_addr == bus.iss_addr)) ||
                      (w_wr1_ok && (bus.wr1_addr == bus.iss_addr));

   // Port 1 applied last so it wins a same-address collision; issue applied
   // after the clears so a new producer supersedes the retiring one.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (w_wr0_ok) begin
         regs_d[bus.wr0_addr] = bus.wr0_data;
         busy_d[bus.wr0_addr] = 1'b0;
      end
      if (w_wr1_ok) begin
         regs_d[bus.wr1_addr] = bus.wr1_data;
         busy_d[bus.wr1_addr] = 1'b0;
      end
      if (w_iss_ok) begin
         busy_d[bus.iss_addr] = 1'b1;
      end
      waw_err_d = waw_err_q | (w_iss_ok && busy_q[bus.iss_addr] && !w_iss_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q    <= '{default: '0};
         busy_q    <= '0;
         waw_err_q <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         busy_q    <= busy_d;
         waw_err_q <= waw_err_d;
      end
   end

   assign bus.waw_err = waw_err_q;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rdata;
      logic              w_rbusy;
      logic              w_hit0, w_hit1;

      assign w_ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

      // Outputs are forced low while reset is held so bypassed write data
      // cannot leak through during reset.
      always_comb begin
         w_hit0  = bus.wr0_en && (bus.wr0_addr == w_ra);
         w_hit1  = bus.wr1_en && (bus.wr1_addr == w_ra);
         w_rdata = regs_q[w_ra];
         w_rbusy = busy_q[w_ra];
         if (BYPASS) begin
            if (w_hit1) begin
               w_rdata = bus.wr1_data;
            end else if (w_hit0) begin
               w_rdata = bus.wr0_data;
            end
            if (w_hit0 || w_hit1) begin
               w_rbusy = 1'b0;
            end
         end
         if (is_zero(w_ra) || !rst_n) begin
            w_rdata = '0;
            w_rbusy = 1'b0;
         end
      end

      assign bus.rd_data[k*DATA_W +: DATA_W] = w_rdata;
      assign bus.rd_busy[k]                  = w_rbusy;
   end
endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_reg_file_mp : bench for reg_file_mp (bypass+zero and plain configs)
// rev 1.0
// ----------------------------------------------------------------------
module tb_reg_file_mp;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_a ();
   reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_b ();

   // dut_a: bypass + hardwired zero; dut_b: no bypass, ordinary r0
   reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b0), .BYPASS(1'b0))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   assign bus_b.rd_addr  = bus_a.rd_addr;
   assign bus_b.wr0_en   = bus_a.wr0_en;
   assign bus_b.wr0_addr = bus_a.wr0_addr;
   assign bus_b.wr0_data = bus_a.wr0_data;
   assign bus_b.wr1_en   = bus_a.wr1_en;
   assign bus_b.wr1_addr = bus_a.wr1_addr;
   assign bus_b.wr1_data = bus_a.wr1_data;
   assign bus_b.iss_en   = bus_a.iss_en;
   assign bus_b.iss_addr = bus_a.iss_addr;

   // Reference model, index 0 = dut_a, index 1 = dut_b
   logic [DW-1:0] m_regs [2][DEPTH];
   bit            m_busy [2][DEPTH];
   bit            m_waw  [2];

   function automatic bit m_zero(int c, logic [AW-1:0] a);
      return (c == 0) && (a == 0);
   endfunction

   function automatic logic [DW-1:0] m_rd(int c, logic [AW-1:0] a);
      if (m_zero(c, a)) return '0;
      if (c == 0 && bus_a.wr1_en && bus_a.wr1_addr == a) return bus_a.wr1_data;
      if (c == 0 && bus_a.wr0_en && bus_a.wr0_addr == a) return bus_a.wr0_data;
      return m_regs[c][a];
   endfunction

   function automatic bit m_bsy(int c, logic [AW-1:0] a);
      if (m_zero(c, a)) return 1'b0;
      if (c == 0 && ((bus_a.wr0_en && bus_a.wr0_addr == a) ||
                     (bus_a.wr1_en && bus_a.wr1_addr == a))) return 1'b0;
      return m_busy[c][a];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_waw[c] = 1'b0;
         for (int r = 0; r < DEPTH; r++) begin
            m_regs[c][r] = '0;
            m_busy[c][r] = 1'b0;
         end
      end
   endtask

   task automatic model_clock();
      for (int c = 0; c < 2; c++) begin
         bit ok0, ok1, oki;
         ok0 = bus_a.wr0_en && !m_zero(c, bus_a.wr0_addr);
         ok1 = bus_a.wr1_en && !m_zero(c, bus_a.wr1_addr);
         oki = bus_a.iss_en && !m_zero(c, bus_a.iss_addr);
         if (oki && m_busy[c][bus_a.iss_addr] &&
             !(ok0 && bus_a.wr0_addr == bus_a.iss_addr) &&
             !(ok1 && bus_a.wr1_addr == bus_a.iss_addr)) m_waw[c] = 1'b1;
         if (ok0) begin m_regs[c][bus_a.wr0_addr] = bus_a.wr0_data; m_busy[c][bus_a.wr0_addr] = 1'b0; end
         if (ok1) begin m_regs[c][bus_a.wr1_addr] = bus_a.wr1_data; m_busy[c][bus_a.wr1_addr] = 1'b0; end
         if (oki) m_busy[c][bus_a.iss_addr] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic idle();
      bus_a.wr0_en = 1'b0; bus_a.wr0_addr = '0; bus_a.wr0_data = '0;
      bus_a.wr1_en = 1'b0; bus_a.wr1_addr = '0; bus_a.wr1_data = '0;
      bus_a.iss_en = 1'b0; bus_a.iss_addr = '0;
   endtask

   task automatic set_rd(logic [AW-1:0] a0, logic [AW-1:0] a1);
      bus_a.rd_addr = {a1, a0};
   endtask

   task automatic test_reset();
      idle();
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5; bus_a.wr0_data = 32'hDEADBEEF;
      bus_a.iss_en = 1'b1; bus_a.iss_addr = 5;
      tick();
      idle(); set_rd(5, 5); #1;
      total++; if (bus_a.rd_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rst_pre_a got=%h exp=%h", bus_a.rd_data[31:0], 32'hDEADBEEF); end
      total++; if (bus_b.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL rst_pre_busy_b got=%b exp=1", bus_b.rd_busy[0]); end
      // Reset asserted mid-cycle while a write to r5 is pending on both ports
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 5; bus_a.wr0_data = 32'h1234;
      bus_a.wr1_en = 1'b1; bus_a.wr1_addr = 5; bus_a.wr1_data = 32'h5678;
      rst_n = 1'b0; #1;
      total++; if (bus_a.rd_data !== '0) begin bad++; $display("FAIL rst_hold_data_a got=%h exp=0", bus_a.rd_data); end
      total++; if (bus_b.rd_data !== '0) begin bad++; $display("FAIL rst_hold_data_b got=%h exp=0", bus_b.rd_data); end
      total++; if (bus_a.rd_busy !== 2'b00 || bus_b.rd_busy !== 2'b00) begin bad++; $display("FAIL rst_hold_busy got=%b/%b exp=00/00", bus_a.rd_busy, bus_b.rd_busy); end
      total++; if (bus_a.waw_err !== 1'b0) begin bad++; $display("FAIL rst_hold_waw got=%b exp=0", bus_a.waw_err); end
      @(posedge clk); @(negedge clk);
      idle(); rst_n = 1'b1; model_reset(); #1;
      total++; if (bus_a.rd_data[31:0] !== 32'h0 || bus_b.rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL rst_discard got=%h/%h exp=0/0", bus_a.rd_data[31:0], bus_b.rd_data[31:0]); end
   endtask

   task automatic test_dual_write();
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 3; bus_a.wr0_data = 32'h11;
      bus_a.wr1_en = 1'b1; bus_a.wr1_addr = 4; bus_a.wr1_data = 32'h22;
      tick();
      idle(); set_rd(3, 4); #1;
      total++; if (bus_a.rd_data !== {32'h22, 32'h11}) begin bad++; $display("FAIL dual_a got=%h exp=%h", bus_a.rd_data, {32'h22, 32'h11}); end
      total++; if (bus_b.rd_data !== {32'h22, 32'h11}) begin bad++; $display("FAIL dual_b got=%h exp=%h", bus_b.rd_data, {32'h22, 32'h11}); end
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 7; bus_a.wr0_data = 32'hAA;
      bus_a.wr1_en = 1'b1; bus_a.wr1_addr = 7; bus_a.wr1_data = 32'hBB;
      tick();
      idle(); set_rd(7, 7); #1;
      total++; if (bus_a.rd_data[31:0] !== 32'hBB) begin bad++; $display("FAIL prio_a got=%h exp=bb", bus_a.rd_data[31:0]); end
      total++; if (bus_b.rd_data[63:32] !== 32'hBB) begin bad++; $display("FAIL prio_b got=%h exp=bb", bus_b.rd_data[63:32]); end
   endtask

   task automatic test_bypass();
      set_rd(0, 9);
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 9; bus_a.wr0_data = 32'h1234; #1;
      total++; if (bus_a.rd_data[63:32] !== 32'h1234) begin bad++; $display("FAIL byp_same_a got=%h exp=1234", bus_a.rd_data[63:32]); end
      total++; if (bus_b.rd_data[63:32] !== 32'h0) begin bad++; $display("FAIL byp_same_b got=%h exp=0", bus_b.rd_data[63:32]); end
      tick();
      idle(); #1;
      total++; if (bus_b.rd_data[63:32] !== 32'h1234) begin bad++; $display("FAIL byp_next_b got=%h exp=1234", bus_b.rd_data[63:32]); end
      total++; if (bus_a.rd_data[63:32] !== 32'h1234) begin bad++; $display("FAIL byp_next_a got=%h exp=1234", bus_a.rd_data[63:32]); end
   endtask

   task automatic test_zero();
      set_rd(0, 0);
      bus_a.wr1_en = 1'b1; bus_a.wr1_addr = 0; bus_a.wr1_data = 32'hFFFFFFFF;
      bus_a.iss_en = 1'b1; bus_a.iss_addr = 0; #1;
      total++; if (bus_a.rd_data !== '0) begin bad++; $display("FAIL zero_same_a got=%h exp=0", bus_a.rd_data); end
      tick();
      idle(); #1;
      total++; if (bus_a.rd_data !== '0 || bus_a.rd_busy !== 2'b00) begin bad++; $display("FAIL zero_a got=%h/%b exp=0/00", bus_a.rd_data, bus_a.rd_busy); end
      total++; if (bus_b.rd_data[31:0] !== 32'hFFFFFFFF || bus_b.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL zero_plain_b got=%h/%b exp=ffffffff/1", bus_b.rd_data[31:0], bus_b.rd_busy[0]); end
      bus_a.iss_en = 1'b1; bus_a.iss_addr = 0;
      tick();
      idle(); #1;
      total++; if (bus_a.waw_err !== 1'b0) begin bad++; $display("FAIL zero_waw_a got=%b exp=0", bus_a.waw_err); end
   endtask

   task automatic test_scoreboard();
      set_rd(12, 1);
      bus_a.iss_en = 1'b1; bus_a.iss_addr = 12; #1;
      total++; if (bus_a.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_iss_same got=%b exp=0", bus_a.rd_busy[0]); end
      tick();
      idle(); #1;
      total++; if (bus_a.rd_busy[0] !== 1'b1 || bus_b.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_set got=%b/%b exp=1/1", bus_a.rd_busy[0], bus_b.rd_busy[0]); end
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 12; bus_a.wr0_data = 32'h55; #1;
      total++; if (bus_a.rd_busy[0] !== 1'b0 || bus_b.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_wb_same got=%b/%b exp=0/1", bus_a.rd_busy[0], bus_b.rd_busy[0]); end
      tick();
      idle(); #1;
      total++; if (bus_a.rd_busy[0] !== 1'b0 || bus_b.rd_busy[0] !== 1'b0 || bus_a.rd_data[31:0] !== 32'h55) begin bad++; $display("FAIL sb_clr got=%b/%b/%h exp=0/0/55", bus_a.rd_busy[0], bus_b.rd_busy[0], bus_a.rd_data[31:0]); end
      bus_a.iss_en = 1'b1; bus_a.iss_addr = 12;
      bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 12; bus_a.wr0_data = 32'h66;
      tick();
      idle(); #1;
      total++; if (bus_a.rd_busy[0] !== 1'b1 || bus_b.rd_busy[0] !== 1'b1 || bus_a.rd_data[31:0] !== 32'h66) begin bad++; $display("FAIL sb_iss_wins got=%b/%b/%h exp=1/1/66", bus_a.rd_busy[0], bus_b.rd_busy[0], bus_a.rd_data[31:0]); end
      total++; if (bus_a.waw_err !== 1'b0) begin bad++; $display("FAIL sb_no_waw got=%b exp=0", bus_a.waw_err); end
      bus_a.wr1_en = 1'b1; bus_a.wr1_addr = 12; bus_a.wr1_data = 32'h77;
      tick();
      idle();
   endtask

   task automatic test_waw();
      set_rd(6, 2);
      bus_a.iss_en = 1'b1; bus_a.iss_addr = 6;
      tick(); #1;
      total++; if (bus_a.waw_err !== 1'b0) begin bad++; $display("FAIL waw_first got=%b exp=0", bus_a.waw_err); end
      tick();
      idle(); #1;
      total++; if (bus_a.waw_err !== 1'b1 || bus_b.waw_err !== 1'b1) begin bad++; $display("FAIL waw_set got=%b/%b exp=1/1", bus_a.waw_err, bus_b.waw_err); end
      for (int i = 0; i < 10; i++) begin
         bus_a.wr0_en = 1'b1; bus_a.wr0_addr = 6; bus_a.wr0_data = 32'(i);
         tick(); #1;
         total++; if (bus_a.waw_err !== 1'b1) begin bad++; $display("FAIL waw_hold cyc=%0d got=%b exp=1", i, bus_a.waw_err); end
      end
      idle();
      rst_n = 1'b0; #1;
      total++; if (bus_a.waw_err !== 1'b0 || bus_b.waw_err !== 1'b0) begin bad++; $display("FAIL waw_rst got=%b/%b exp=0/0", bus_a.waw_err, bus_b.waw_err); end
      rst_n = 1'b1; model_reset();
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH-1));
   endfunction

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         if (n == 200) begin rst_n = 1'b0; #1; rst_n = 1'b1; model_reset(); end
         bus_a.wr0_en = 1'($urandom_range(0, 1)); bus_a.wr0_addr = rnd_addr(); bus_a.wr0_data = $urandom;
         bus_a.wr1_en = 1'($urandom_range(0, 1)); bus_a.wr1_addr = rnd_addr(); bus_a.wr1_data = $urandom;
         bus_a.iss_en = ($urandom_range(0, 3) == 0); bus_a.iss_addr = rnd_addr();
         set_rd(($urandom_range(0, 1) == 1) ? bus_a.wr0_addr : rnd_addr(),
                ($urandom_range(0, 1) == 1) ? bus_a.wr1_addr : rnd_addr());
         #1;
         for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] a;
            a = bus_a.rd_addr[k*AW +: AW];
            total++; if (bus_a.rd_data[k*DW +: DW] !== m_rd(0, a)) begin bad++; $display("FAIL rnd_data_a n=%0d p=%0d a=%0d got=%h exp=%h", n, k, a, bus_a.rd_data[k*DW +: DW], m_rd(0, a)); end
            total++; if (bus_b.rd_data[k*DW +: DW] !== m_rd(1, a)) begin bad++; $display("FAIL rnd_data_b n=%0d p=%0d a=%0d got=%h exp=%h", n, k, a, bus_b.rd_data[k*DW +: DW], m_rd(1, a)); end
            total++; if (bus_a.rd_busy[k] !== m_bsy(0, a)) begin bad++; $display("FAIL rnd_busy_a n=%0d p=%0d a=%0d got=%b exp=%b", n, k, a, bus_a.rd_busy[k], m_bsy(0, a)); end
            total++; if (bus_b.rd_busy[k] !== m_bsy(1, a)) begin bad++; $display("FAIL rnd_busy_b n=%0d p=%0d a=%0d got=%b exp=%b", n, k, a, bus_b.rd_busy[k], m_bsy(1, a)); end
         end
         total++; if (bus_a.waw_err !== m_waw[0] || bus_b.waw_err !== m_waw[1]) begin bad++; $display("FAIL rnd_waw n=%0d got=%b/%b exp=%b/%b", n, bus_a.waw_err, bus_b.waw_err, m_waw[0], m_waw[1]); end
         tick();
      end
      idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      set_rd(0, 0);
      model_reset();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_dual_write();
      test_bypass();
      test_zero();
      test_scoreboard();
      test_waw();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
